// File: rtl/ter_pkg.sv
// ter_pkg: shared types, constants and helpers for balanced-ternary vector ops.
//   ter_t    : one ternary coefficient, 00 = 0, 01 = +1, 11 = -1 (10 unused)
//   op_e     : ADD (a+b), SUB (a-b), NEG (-a); encoding 11 is illegal
//   state_e  : sequencer states of ter_vec_sched
//   ter_neg  : negate one coefficient
//   add_ter  : mod-3 sum of two coefficients
package ter_pkg;

    typedef logic [1:0] ter_t;

    localparam ter_t TER_ZERO = 2'b00;
    localparam ter_t TER_POS  = 2'b01;
    localparam ter_t TER_NEG  = 2'b11;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_NEG = 2'b10
    } op_e;

    localparam logic [1:0] OP_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_DRAIN = 2'b10,
        S_DONE  = 2'b11
    } state_e;

    // Negation only touches nonzero codes: 01 <-> 11, 00 stays 00.
    function automatic ter_t ter_neg(input ter_t x);
        return {x[1] ^ x[0], x[0]};
    endfunction

    // Sum mod 3 in {0, +1, -1}; +1 + +1 wraps to -1 and -1 + -1 wraps to +1.
    function automatic ter_t add_ter(input ter_t a, input ter_t b);
        ter_t r;
        case ({a, b})
            {TER_ZERO, TER_ZERO}: r = TER_ZERO;
            {TER_ZERO, TER_POS }: r = TER_POS;
            {TER_ZERO, TER_NEG }: r = TER_NEG;
            {TER_POS,  TER_ZERO}: r = TER_POS;
            {TER_POS,  TER_POS }: r = TER_NEG;
            {TER_POS,  TER_NEG }: r = TER_ZERO;
            {TER_NEG,  TER_ZERO}: r = TER_NEG;
            {TER_NEG,  TER_POS }: r = TER_ZERO;
            {TER_NEG,  TER_NEG }: r = TER_POS;
            default:              r = TER_ZERO;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ter_lane_alu.sv
// ter_lane_alu: one lane of the ternary vector datapath (combinational).
//   a, b : ternary input coefficients
//   op   : latched operation (ADD / SUB / NEG)
//   c    : ternary result; 00 for the unused op encoding
module ter_lane_alu
    import ter_pkg::*;
(
    input  logic [1:0] a,
    input  logic [1:0] b,
    input  logic [1:0] op,
    output logic [1:0] c
);

    always_comb begin
        c = TER_ZERO;
        case (op)
            OP_ADD:  c = add_ter(a, b);
            OP_SUB:  c = add_ter(a, ter_neg(b));
            // NEG reuses the adder with a zero operand so every op shares one path.
            OP_NEG:  c = add_ter(TER_ZERO, ter_neg(a));
            default: c = TER_ZERO;
        endcase
    end

endmodule

// File: rtl/ter_vec_sched.sv
// ter_vec_sched: sequences c = a op b over ternary coefficient memories,
// LANES coefficients per word, one word per granted cycle.
//   clk, rst          : clock, asynchronous active-high reset
//   start, op         : request and operation (sampled only in IDLE)
//   busy, done, err   : status; done / err are one-cycle pulses
//   rd_en, rd_addr    : read request to the A and B RAMs
//   mem_gnt           : read grant
//   a_data, b_data    : read data, valid one cycle after an issued read
//   wr_en, wr_addr,
//   wr_data, wr_mask  : C RAM write port with per-lane enables
//
// Read handshake: a read issues in a cycle where rd_en and mem_gnt are both
// high; rd_addr is held steady while rd_en is high and mem_gnt is low.
module ter_vec_sched
    import ter_pkg::*;
#(
    parameter int N     = 701,
    parameter int LANES = 2,
    parameter int AW    = $clog2((N + LANES - 1) / LANES)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [1:0]           op,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic                 rd_en,
    output logic [AW-1:0]        rd_addr,
    input  logic                 mem_gnt,
    input  logic [2*LANES-1:0]   a_data,
    input  logic [2*LANES-1:0]   b_data,
    output logic                 wr_en,
    output logic [AW-1:0]        wr_addr,
    output logic [2*LANES-1:0]   wr_data,
    output logic [LANES-1:0]     wr_mask
);

    localparam int WORDS = (N + LANES - 1) / LANES;
    localparam int REM   = N % LANES;
    localparam logic [AW-1:0] LAST_ADDR = AW'(WORDS - 1);

    state_e             state;
    logic [1:0]         op_q;
    logic [AW-1:0]      rd_ptr;
    logic               v1;        // read data is on a_data/b_data this cycle
    logic [AW-1:0]      addr1;     // word address of that read data
    logic               issue;
    logic [2*LANES-1:0] alu_c;
    logic [2*LANES-1:0] data_next;
    logic [LANES-1:0]   mask_next;

    assign issue   = (state == S_RUN) && mem_gnt;
    assign rd_en   = (state == S_RUN);
    assign rd_addr = rd_ptr;
    assign busy    = (state == S_RUN) || (state == S_DRAIN);
    assign done    = (state == S_DONE);

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        ter_lane_alu u_alu (
            .a  (a_data[2*g +: 2]),
            .b  (b_data[2*g +: 2]),
            .op (op_q),
            .c  (alu_c[2*g +: 2])
        );
    end

    // Only the final word can be partial; its lanes beyond N are disabled
    // and their data zeroed so the C RAM never sees stale coefficients.
    always_comb begin
        mask_next = '1;
        data_next = '0;
        if (REM != 0 && addr1 == LAST_ADDR) begin
            for (int k = 0; k < LANES; k++) begin
                mask_next[k] = (k < REM);
            end
        end
        for (int k = 0; k < LANES; k++) begin
            data_next[2*k +: 2] = mask_next[k] ? alu_c[2*k +: 2] : TER_ZERO;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            op_q    <= 2'b00;
            rd_ptr  <= '0;
            v1      <= 1'b0;
            addr1   <= '0;
            err     <= 1'b0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            wr_mask <= '0;
        end else begin
            err   <= 1'b0;
            v1    <= issue;
            wr_en <= v1;
            if (issue) begin
                addr1 <= rd_ptr;
            end
            if (v1) begin
                wr_addr <= addr1;
                wr_data <= data_next;
                wr_mask <= mask_next;
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (op == OP_ILLEGAL) begin
                            err <= 1'b1;
                        end else begin
                            op_q   <= op;
                            rd_ptr <= '0;
                            state  <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    // The pointer parks on the last word so it never wraps.
                    if (mem_gnt) begin
                        if (rd_ptr == LAST_ADDR) begin
                            state <= S_DRAIN;
                        end else begin
                            rd_ptr <= rd_ptr + 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    // No reads are in flight after this, so the last-address write ends the job.
                    if (wr_en && wr_addr == LAST_ADDR) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ter_vec_sched.sv
module tb_ter_vec_sched;

    localparam int W = 10; // {addr[3:0], data[3:0], mask[1:0]}

    typedef struct {
        logic        sel;    // 0: N=4 instance, 1: N=5 instance
        logic [1:0]  op;
        logic [11:0] a;      // word w at [4w+3:4w]
        logic [11:0] b;
        logic [11:0] c;
        logic [5:0]  m;      // mask for word w at [2w+1:2w]
    } vec_t;

    // ---------------- clock / reset / signals ----------------
    logic clk, rst, sel;
    logic start4, start5;
    logic [1:0] op;
    logic mem_gnt;
    logic [3:0] a_data, b_data;

    logic busy4, done4, err4, rd_en4, wr_en4;
    logic [0:0] rd_addr4, wr_addr4;
    logic [3:0] wr_data4;
    logic [1:0] wr_mask4;
    logic busy5, done5, err5, rd_en5, wr_en5;
    logic [1:0] rd_addr5, wr_addr5;
    logic [3:0] wr_data5;
    logic [1:0] wr_mask5;

    logic m_busy, m_done, m_err, m_rd_en, m_wr_en;
    logic [3:0] m_rd_addr, m_wr_addr, m_wr_data;
    logic [1:0] m_wr_mask;

    logic [3:0] mem_a[0:3];
    logic [3:0] mem_b[0:3];

    int n_checks, n_errors, cyc, done_cnt, err_cnt, done_cyc;
    logic gnt_rand;

    logic [W-1:0] exp_q[$];
    int           iss_cyc[$];
    logic [3:0]   iss_addr[$];
    int           iss_log[$];
    int           wr_log[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    ter_vec_sched #(.N(4), .LANES(2)) u_d4 (
        .clk(clk), .rst(rst), .start(start4), .op(op),
        .busy(busy4), .done(done4), .err(err4),
        .rd_en(rd_en4), .rd_addr(rd_addr4), .mem_gnt(mem_gnt),
        .a_data(a_data), .b_data(b_data),
        .wr_en(wr_en4), .wr_addr(wr_addr4), .wr_data(wr_data4), .wr_mask(wr_mask4)
    );

    ter_vec_sched #(.N(5), .LANES(2)) u_d5 (
        .clk(clk), .rst(rst), .start(start5), .op(op),
        .busy(busy5), .done(done5), .err(err5),
        .rd_en(rd_en5), .rd_addr(rd_addr5), .mem_gnt(mem_gnt),
        .a_data(a_data), .b_data(b_data),
        .wr_en(wr_en5), .wr_addr(wr_addr5), .wr_data(wr_data5), .wr_mask(wr_mask5)
    );

    assign m_busy    = sel ? busy5 : busy4;
    assign m_done    = sel ? done5 : done4;
    assign m_err     = sel ? err5  : err4;
    assign m_rd_en   = sel ? rd_en5 : rd_en4;
    assign m_wr_en   = sel ? wr_en5 : wr_en4;
    assign m_rd_addr = sel ? {2'b00, rd_addr5} : {3'b000, rd_addr4};
    assign m_wr_addr = sel ? {2'b00, wr_addr5} : {3'b000, wr_addr4};
    assign m_wr_data = sel ? wr_data5 : wr_data4;
    assign m_wr_mask = sel ? wr_mask5 : wr_mask4;

    // A/B RAM model: data for a granted read appears the next cycle,
    // otherwise the bus carries junk.
    always @(posedge clk) begin
        if (m_rd_en && mem_gnt) begin
            a_data <= mem_a[m_rd_addr[1:0]];
            b_data <= mem_b[m_rd_addr[1:0]];
        end else begin
            a_data <= 4'($urandom);
            b_data <= 4'($urandom);
        end
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name, input logic [31:0] act);
        n_checks++;
        n_errors++;
        $display("FAIL %s: got 0x%0h expected none (t=%0t)", name, act, $time);
    endtask

    // ---------------- reference model ----------------
    function automatic int dec(input logic [1:0] t);
        case (t)
            2'b01:   return 1;
            2'b11:   return -1;
            default: return 0;
        endcase
    endfunction

    function automatic logic [1:0] enc(input int v);
        int m;
        m = ((v % 3) + 3) % 3;
        case (m)
            1:       return 2'b01;
            2:       return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [W-1:0] ref_word(input int n, input int w, input logic [1:0] o);
        logic [3:0] d;
        logic [1:0] m;
        int va, vb, r;
        d = '0;
        m = '0;
        for (int k = 0; k < 2; k++) begin
            if (w * 2 + k < n) begin
                va = dec(mem_a[w][2*k +: 2]);
                vb = dec(mem_b[w][2*k +: 2]);
                case (o)
                    2'b00:   r = va + vb;
                    2'b01:   r = va - vb;
                    default: r = -va;
                endcase
                d[2*k +: 2] = enc(r);
                m[k] = 1'b1;
            end
        end
        return {4'(w), d, m};
    endfunction

    task automatic push_expected(input logic [1:0] o);
        int n;
        n = sel ? 5 : 4;
        for (int w = 0; w < (n + 1) / 2; w++) exp_q.push_back(ref_word(n, w, o));
    endtask

    function automatic logic [3:0] rnd_word();
        logic [3:0] x;
        for (int k = 0; k < 2; k++) begin
            case ($urandom_range(0, 2))
                0:       x[2*k +: 2] = 2'b00;
                1:       x[2*k +: 2] = 2'b01;
                default: x[2*k +: 2] = 2'b11;
            endcase
        end
        return x;
    endfunction

    task automatic fill_random();
        for (int w = 0; w < 4; w++) begin
            mem_a[w] = rnd_word();
            mem_b[w] = rnd_word();
        end
    endtask

    // ---------------- scoreboard / monitor ----------------
    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            if (m_wr_en) begin
                wr_log.push_back(cyc);
                if (exp_q.size() == 0) fail_now("unexpected_write", 32'({m_wr_addr, m_wr_data, m_wr_mask}));
                else check("wr_word", 32'({m_wr_addr, m_wr_data, m_wr_mask}), 32'(exp_q.pop_front()));
                if (iss_cyc.size() == 0) fail_now("write_without_read", 32'(m_wr_addr));
                else begin
                    check("wr_latency", 32'(cyc - iss_cyc.pop_front()), 32'd2);
                    check("wr_addr_vs_read", 32'(m_wr_addr), 32'(iss_addr.pop_front()));
                end
            end
            if (m_rd_en && mem_gnt) begin
                iss_cyc.push_back(cyc);
                iss_addr.push_back(m_rd_addr);
                iss_log.push_back(cyc);
            end
            if (m_done) begin
                done_cnt++;
                done_cyc = cyc;
                check("done_not_busy", 32'(m_busy), 32'd0);
            end
            if (m_err) err_cnt++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic clear_logs();
        exp_q.delete();
        iss_log.delete();
        wr_log.delete();
    endtask

    task automatic do_start(input logic [1:0] o);
        @(posedge clk); #1;
        op = o;
        if (sel) start5 = 1'b1; else start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        start5 = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int s, i;
        s = done_cnt;
        i = 0;
        while (done_cnt == s && i < budget) begin
            @(posedge clk); #1;
            if (gnt_rand) mem_gnt = ($urandom_range(0, 3) != 0);
            i++;
        end
        check("done_seen", 32'(done_cnt - s), 32'd1);
        repeat (3) begin @(posedge clk); #1; end
        check("single_done", 32'(done_cnt - s), 32'd1);
        check("all_writes", 32'(exp_q.size()), 32'd0);
        check("idle_after_done", 32'(m_busy), 32'd0);
        if (wr_log.size() > 0) check("done_after_last_write", 32'(done_cyc), 32'(wr_log[wr_log.size()-1] + 1));
    endtask

    task automatic run_vec(input vec_t v);
        int words;
        sel = v.sel;
        words = v.sel ? 3 : 2;
        for (int w = 0; w < 4; w++) begin
            mem_a[w] = (w < 3) ? v.a[4*w +: 4] : 4'h0;
            mem_b[w] = (w < 3) ? v.b[4*w +: 4] : 4'h0;
        end
        clear_logs();
        for (int w = 0; w < words; w++) exp_q.push_back({4'(w), v.c[4*w +: 4], v.m[2*w +: 2]});
        mem_gnt = 1'b1;
        do_start(v.op);
        wait_done(40);
    endtask

    // ---------------- main sequence ----------------
    vec_t vecs[4];

    initial begin
        int s;
        rst = 1'b1; sel = 1'b0; start4 = 1'b0; start5 = 1'b0; op = 2'b00;
        mem_gnt = 1'b1; gnt_rand = 1'b0;
        n_checks = 0; n_errors = 0; cyc = 0; done_cnt = 0; err_cnt = 0; done_cyc = 0;
        for (int w = 0; w < 4; w++) begin mem_a[w] = '0; mem_b[w] = '0; end

        vecs[0] = '{sel: 1'b0, op: 2'b00, a: {4'h0, 4'b0011, 4'b0101}, b: {4'h0, 4'b0111, 4'b1101},
                    c: {4'h0, 4'b0101, 4'b0011}, m: {2'b00, 2'b11, 2'b11}};
        vecs[1] = '{sel: 1'b1, op: 2'b01, a: {4'b0101, 4'b0101, 4'b0101}, b: {4'b1111, 4'b1111, 4'b1111},
                    c: {4'b0011, 4'b1111, 4'b1111}, m: {2'b01, 2'b11, 2'b11}};
        vecs[2] = '{sel: 1'b0, op: 2'b10, a: {4'h0, 4'b0100, 4'b1101}, b: {4'h0, 4'b1111, 4'b0101},
                    c: {4'h0, 4'b1100, 4'b0111}, m: {2'b00, 2'b11, 2'b11}};
        vecs[3] = '{sel: 1'b1, op: 2'b10, a: {4'b0111, 4'b0100, 4'b1101}, b: {4'b0101, 4'b0011, 4'b1111},
                    c: {4'b0001, 4'b1100, 4'b0111}, m: {2'b01, 2'b11, 2'b11}};

        repeat (3) @(posedge clk);
        #1;
        check("reset_outs_n4", 32'({busy4, done4, err4, rd_en4, rd_addr4, wr_en4, wr_addr4, wr_data4, wr_mask4}), 32'd0);
        check("reset_outs_n5", 32'({busy5, done5, err5, rd_en5, rd_addr5, wr_en5, wr_addr5, wr_data5, wr_mask5}), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Table vectors
        for (int i = 0; i < 4; i++) begin
            run_vec(vecs[i]);
            if (i == 0) begin
                check("t1_write_count", 32'(wr_log.size()), 32'd2);
                if (wr_log.size() >= 2 && iss_log.size() >= 1) begin
                    check("t1_first_write_cycle", 32'(wr_log[0] - iss_log[0]), 32'd2);
                    check("t1_second_write_cycle", 32'(wr_log[1] - iss_log[0]), 32'd3);
                end
            end
        end

        // NEG with a two-cycle grant stall before the second read
        sel = 1'b0;
        mem_a[0] = 4'b1101; mem_a[1] = 4'b0100;
        mem_b[0] = rnd_word(); mem_b[1] = rnd_word();
        clear_logs();
        push_expected(2'b10);
        mem_gnt = 1'b1;
        do_start(2'b10);
        check("stall_rd_en_c0", 32'(m_rd_en), 32'd1);
        check("stall_rd_addr_c0", 32'(m_rd_addr), 32'd0);
        @(posedge clk); #1;
        mem_gnt = 1'b0;
        check("stall_rd_addr_c1", 32'(m_rd_addr), 32'd1);
        @(posedge clk); #1;
        check("stall_rd_addr_c2", 32'(m_rd_addr), 32'd1);
        check("stall_rd_en_c2", 32'(m_rd_en), 32'd1);
        @(posedge clk); #1;
        check("stall_rd_addr_c3", 32'(m_rd_addr), 32'd1);
        mem_gnt = 1'b1;
        wait_done(40);
        if (wr_log.size() >= 2) check("stall_write_gap", 32'(wr_log[1] - wr_log[0]), 32'd3);
        else check("stall_write_count", 32'(wr_log.size()), 32'd2);

        // Illegal op, then a legal run
        sel = 1'b0;
        s = err_cnt;
        do_start(2'b11);
        check("err_pulse", 32'(m_err), 32'd1);
        check("err_not_busy", 32'(m_busy), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("err_quiet", 32'({m_err, m_busy, m_rd_en, m_wr_en}), 32'd0);
        end
        check("err_count", 32'(err_cnt - s), 32'd1);
        fill_random();
        clear_logs();
        push_expected(2'b00);
        do_start(2'b00);
        wait_done(40);

        // Start pulsed while busy and op changed mid-run: latched op wins
        sel = 1'b1;
        fill_random();
        clear_logs();
        push_expected(2'b00);
        do_start(2'b00);
        start5 = 1'b1; op = 2'b01;
        @(posedge clk); #1;
        start5 = 1'b0; op = 2'b10;
        wait_done(40);

        // Start arriving in DONE is ignored
        sel = 1'b0;
        fill_random();
        clear_logs();
        push_expected(2'b01);
        s = done_cnt;
        do_start(2'b01);
        repeat (4) begin @(posedge clk); #1; end
        check("done_cycle4", 32'(m_done), 32'd1);
        start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("done_start_ignored", 32'(m_busy), 32'd0);
            @(posedge clk); #1;
        end
        check("done_start_one_done", 32'(done_cnt - s), 32'd1);
        check("done_start_writes", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset in the middle of a run
        sel = 1'b1;
        fill_random();
        clear_logs();
        push_expected(2'b00);
        do_start(2'b00);
        @(posedge clk); #1;
        @(posedge clk); #3;
        check("pre_reset_write", 32'(m_wr_en), 32'd1);
        rst = 1'b1;
        #1;
        check("reset_drop", 32'({m_busy, m_rd_en, m_wr_en}), 32'd0);
        exp_q.delete(); iss_cyc.delete(); iss_addr.delete();
        s = done_cnt;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        check("no_done_after_reset", 32'(done_cnt - s), 32'd0);
        fill_random();
        clear_logs();
        push_expected(2'b10);
        do_start(2'b10);
        wait_done(40);

        // Randomized runs against the reference model, random grant stalls
        for (int r = 0; r < 24; r++) begin
            sel = 1'($urandom_range(0, 1));
            fill_random();
            clear_logs();
            op = 2'($urandom_range(0, 2));
            push_expected(op);
            gnt_rand = 1'b1;
            mem_gnt = ($urandom_range(0, 3) != 0);
            do_start(op);
            wait_done(120);
            gnt_rand = 1'b0;
            mem_gnt = 1'b1;
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #300000;
        n_checks++;
        n_errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
